// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Packs an incoming byte stream big-endian into 512-bit blocks, then appends
// the 0x80 terminator, the zero fill and the 64-bit message bit length.
// Each finished block is offered to the compression core over valid/ready.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   data_in,
    input  logic         data_valid,
    input  logic         data_last,
    output logic         in_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready,
    output logic         err_overflow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABSORB = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_LEN    = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       ret_state;
    logic [511:0]     buffer;
    logic [6:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       slot_hi;
    logic [63:0]      bit_len;

    // Top bit of the byte slot selected by idx; byte 0 sits in the MSBs.
    assign slot_hi   = 9'd511 - {idx[5:0], 3'b000};
    // Message length in bits, zero-extended to the 64-bit trailer.
    assign bit_len   = 64'(cnt) << 3;
    assign in_ready  = (state == S_ABSORB);
    assign block_out = buffer;

    // Main sequencer: absorb bytes, pad, append length and hand blocks out.
    // The buffer is cleared after every handshake, so the zero fill never
    // has to be written explicitly. ret_state remembers where to resume
    // once the core has taken the current block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ret_state    <= S_IDLE;
            buffer       <= '0;
            idx          <= '0;
            cnt          <= '0;
            block_valid  <= 1'b0;
            block_last   <= 1'b0;
            err_overflow <= 1'b0;
        end else if (start) begin
            state        <= S_ABSORB;
            ret_state    <= S_IDLE;
            buffer       <= '0;
            idx          <= '0;
            cnt          <= '0;
            block_valid  <= 1'b0;
            block_last   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (data_valid && (state == S_PAD || state == S_LEN || state == S_EMIT)) begin
                err_overflow <= 1'b1;
            end

            case (state)
                S_ABSORB: begin
                    if (data_valid) begin
                        buffer[slot_hi -: 8] <= data_in;
                        idx                  <= idx + 7'd1;
                        cnt                  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (data_last) begin
                            state <= S_PAD;
                        end else if (idx == 7'd63) begin
                            state       <= S_EMIT;
                            block_valid <= 1'b1;
                            block_last  <= 1'b0;
                            ret_state   <= S_ABSORB;
                        end
                    end else if (data_last) begin
                        state <= S_PAD;
                    end
                end

                S_PAD: begin
                    if (idx == 7'd64) begin
                        state       <= S_EMIT;
                        block_valid <= 1'b1;
                        block_last  <= 1'b0;
                        ret_state   <= S_PAD;
                    end else begin
                        buffer[slot_hi -: 8] <= 8'h80;
                        idx                  <= idx + 7'd1;
                        if (idx <= 7'd55) begin
                            state <= S_LEN;
                        end else begin
                            state       <= S_EMIT;
                            block_valid <= 1'b1;
                            block_last  <= 1'b0;
                            ret_state   <= S_LEN;
                        end
                    end
                end

                S_LEN: begin
                    buffer[63:0] <= bit_len;
                    state        <= S_EMIT;
                    block_valid  <= 1'b1;
                    block_last   <= 1'b1;
                    ret_state    <= S_IDLE;
                end

                S_EMIT: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        block_last  <= 1'b0;
                        buffer      <= '0;
                        idx         <= '0;
                        state       <= ret_state;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
